// File: rtl/cpu_pkg.sv
// Shared CPU definitions: field widths, opcode encodings and the fetch FSM state type.
// Used by the fetch stage. The control unit decodes the same opcode values.
package cpu_pkg;

  localparam int ADDR_W  = 8;
  localparam int OPC_W   = 4;
  localparam int INSTR_W = 12;

  localparam logic [3:0] OPC_ADD  = 4'h0;
  localparam logic [3:0] OPC_SUB  = 4'h1;
  localparam logic [3:0] OPC_AND  = 4'h2;
  localparam logic [3:0] OPC_OR   = 4'h3;
  localparam logic [3:0] OPC_XOR  = 4'h4;
  localparam logic [3:0] OPC_LD   = 4'h5;
  localparam logic [3:0] OPC_ST   = 4'h6;
  localparam logic [3:0] OPC_JMP  = 4'h7;
  localparam logic [3:0] OPC_JZ   = 4'h8;
  localparam logic [3:0] OPC_ADDI = 4'h9;
  localparam logic [3:0] OPC_ANDI = 4'hA;
  localparam logic [3:0] OPC_HLT  = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    ISSUE,
    HALTED
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: the program-memory read port plus the instruction/PC-redirect handshake with the CU.
// The master modport is the fetch side; the slave modport is the memory/CU side.
interface fetch_unit_if #(
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int OPC_W   = cpu_pkg::OPC_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
);

  logic                     imem_req;
  logic [ADDR_W-1:0]        imem_addr;
  logic [INSTR_W-1:0]       imem_rdata;
  logic                     imem_rvalid;
  logic [OPC_W-1:0]         opcode;
  logic [INSTR_W-OPC_W-1:0] operand;
  logic                     instr_valid;
  logic                     instr_ready;
  logic                     pc_load;
  logic [ADDR_W-1:0]        jump_target;
  logic [ADDR_W-1:0]        pc;
  logic                     halted;

  modport master (
    output imem_req, imem_addr, opcode, operand, instr_valid, pc, halted,
    input  imem_rdata, imem_rvalid, instr_ready, pc_load, jump_target
  );

  modport slave (
    input  imem_req, imem_addr, opcode, operand, instr_valid, pc, halted,
    output imem_rdata, imem_rvalid, instr_ready, pc_load, jump_target
  );

endinterface

// File: rtl/pc_counter.sv
// Program counter: a jump load takes priority over increment, and the increment wraps modulo 2^W.
// Updates one cycle after load_i/inc_i. Holds its value when neither is asserted.
module pc_counter #(
  parameter int W = cpu_pkg::ADDR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_value_i,
  input  logic         inc_i,
  output logic [W-1:0] pc_o
);
  import cpu_pkg::*;

  logic [W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_value_i;
    end else if (inc_i) begin
      pc_d = pc_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Non-prefetching fetch stage: IDLE->REQ->WAIT->ISSUE, at least 3 cycles per instruction. It holds the IR while instr_ready is low.
// Optional FETCH_HALT_EN: an accepted all-ones opcode parks the FSM in HALTED until reset.
module fetch_unit #(
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int OPC_W   = cpu_pkg::OPC_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);
  import cpu_pkg::*;

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               pc_ld;
  logic               pc_inc;
  logic               halt_hit;
  logic [ADDR_W-1:0]  pc;

`ifdef FETCH_HALT_EN
  assign halt_hit = (ir_q[INSTR_W-1 -: OPC_W] == {OPC_W{1'b1}});
`else
  assign halt_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_ld   = 1'b0;
    pc_inc  = 1'b0;
    case (state_q)
      IDLE:  state_d = REQ;
      REQ:   state_d = WAIT;
      // rvalid is honoured only here, so a stale or spurious strobe never reaches the IR.
      WAIT: begin
        if (bus.imem_rvalid) begin
          ir_d    = bus.imem_rdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.instr_ready) begin
          pc_ld   = bus.pc_load;
          pc_inc  = !bus.pc_load;
          state_d = halt_hit ? HALTED : REQ;
        end
      end
`ifdef FETCH_HALT_EN
      HALTED: state_d = HALTED;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  pc_counter #(
    .W (ADDR_W)
  ) u_pc (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (pc_ld),
    .load_value_i (bus.jump_target),
    .inc_i        (pc_inc),
    .pc_o         (pc)
  );

  assign bus.imem_req    = (state_q == REQ);
  assign bus.imem_addr   = pc;
  assign bus.pc          = pc;
  assign bus.opcode      = ir_q[INSTR_W-1 -: OPC_W];
  assign bus.operand     = ir_q[INSTR_W-OPC_W-1:0];
  assign bus.instr_valid = (state_q == ISSUE);
`ifdef FETCH_HALT_EN
  assign bus.halted      = (state_q == HALTED);
`else
  assign bus.halted      = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, basic fetch, issue stall, jump/wrap, late/spurious rvalid, reset in WAIT, halt opcode.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called during a REQ cycle: data arrives lat cycles into WAIT, leaving the FSM in ISSUE.
  task automatic respond(input logic [11:0] data, input int lat);
    tick();
    repeat (lat - 1) tick();
    bus.imem_rdata  = data;
    bus.imem_rvalid = 1'b1;
    tick();
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
  endtask

  task automatic accept(input logic ld, input logic [7:0] tgt);
    bus.instr_ready = 1'b1;
    bus.pc_load     = ld;
    bus.jump_target = tgt;
    tick();
    bus.instr_ready = 1'b0;
    bus.pc_load     = 1'b0;
    bus.jump_target = '0;
  endtask

  task automatic test_reset;
    bus.imem_rdata = '0; bus.imem_rvalid = 1'b0; bus.instr_ready = 1'b0;
    bus.pc_load = 1'b0; bus.jump_target = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (bus.pc !== 8'h00) begin errors++; $display("FAIL rst_pc got=%h exp=00", bus.pc); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", bus.instr_valid); end
    checks++; if (bus.opcode !== 4'h0) begin errors++; $display("FAIL rst_opcode got=%h exp=0", bus.opcode); end
    checks++; if (bus.operand !== 8'h00) begin errors++; $display("FAIL rst_operand got=%h exp=00", bus.operand); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", bus.imem_req); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL rst_halted got=%b exp=0", bus.halted); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL idle_req got=%b exp=0", bus.imem_req); end
    tick();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin errors++; $display("FAIL first_req req=%b addr=%h exp req=1 addr=00", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_basic_fetch;
    respond(12'h0A5, 1);
    checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", bus.instr_valid); end
    checks++; if (bus.opcode !== 4'h0 || bus.operand !== 8'hA5) begin errors++; $display("FAIL basic_fields got=%h/%h exp=0/a5", bus.opcode, bus.operand); end
    accept(1'b0, 8'h00);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h01) begin errors++; $display("FAIL basic_next req=%b addr=%h exp req=1 addr=01", bus.imem_req, bus.imem_addr); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL basic_drop got=%b exp=0", bus.instr_valid); end
  endtask

  task automatic test_hold;
    respond(12'h3C7, 1);
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.instr_valid !== 1'b1 || bus.opcode !== 4'h3 || bus.operand !== 8'hC7) begin errors++; $display("FAIL hold_ir[%0d] v=%b op=%h opd=%h exp 1/3/c7", i, bus.instr_valid, bus.opcode, bus.operand); end
      checks++; if (bus.imem_req !== 1'b0 || bus.pc !== 8'h01) begin errors++; $display("FAIL hold_pc[%0d] req=%b pc=%h exp req=0 pc=01", i, bus.imem_req, bus.pc); end
      tick();
    end
    accept(1'b1, 8'h40);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h40) begin errors++; $display("FAIL jump_40 req=%b addr=%h exp req=1 addr=40", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_jump_wrap;
    respond(12'h512, 1);
    checks++; if (bus.opcode !== 4'h5 || bus.operand !== 8'h12) begin errors++; $display("FAIL jw_fields got=%h/%h exp=5/12", bus.opcode, bus.operand); end
    accept(1'b1, 8'hFF);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'hFF) begin errors++; $display("FAIL jump_ff req=%b addr=%h exp req=1 addr=ff", bus.imem_req, bus.imem_addr); end
    respond(12'h700, 1);
    accept(1'b0, 8'h55);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin errors++; $display("FAIL wrap req=%b addr=%h exp req=1 addr=00", bus.imem_req, bus.imem_addr); end
    checks++; if (bus.pc !== 8'h00) begin errors++; $display("FAIL wrap_pc got=%h exp=00", bus.pc); end
  endtask

  task automatic test_delay_spurious;
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.imem_rdata = 12'hBAD;
      checks++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL wait[%0d] v=%b req=%b exp 0/0", i, bus.instr_valid, bus.imem_req); end
      tick();
    end
    bus.imem_rdata = 12'h9E1; bus.imem_rvalid = 1'b1;
    tick();
    bus.imem_rvalid = 1'b0;
    checks++; if (bus.instr_valid !== 1'b1 || bus.opcode !== 4'h9 || bus.operand !== 8'hE1) begin errors++; $display("FAIL late_data v=%b op=%h opd=%h exp 1/9/e1", bus.instr_valid, bus.opcode, bus.operand); end
    bus.imem_rdata = 12'h777; bus.imem_rvalid = 1'b1;
    tick();
    bus.imem_rvalid = 1'b0;
    tick();
    checks++; if (bus.instr_valid !== 1'b1 || bus.opcode !== 4'h9 || bus.operand !== 8'hE1) begin errors++; $display("FAIL spur_issue v=%b op=%h opd=%h exp 1/9/e1", bus.instr_valid, bus.opcode, bus.operand); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL spur_req got=%b exp=0", bus.imem_req); end
    accept(1'b0, 8'h00);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h01) begin errors++; $display("FAIL after_late req=%b addr=%h exp req=1 addr=01", bus.imem_req, bus.imem_addr); end
    // Pulse during REQ must be ignored; the FSM still waits for a WAIT-phase response.
    bus.imem_rdata = 12'h123; bus.imem_rvalid = 1'b1;
    tick();
    bus.imem_rvalid = 1'b0;
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL spur_req_phase got=%b exp=0", bus.instr_valid); end
    bus.imem_rdata = 12'h2AB; bus.imem_rvalid = 1'b1;
    tick();
    bus.imem_rvalid = 1'b0;
    checks++; if (bus.instr_valid !== 1'b1 || bus.opcode !== 4'h2 || bus.operand !== 8'hAB) begin errors++; $display("FAIL post_spur v=%b op=%h opd=%h exp 1/2/ab", bus.instr_valid, bus.opcode, bus.operand); end
    accept(1'b0, 8'h00);
    checks++; if (bus.imem_addr !== 8'h02) begin errors++; $display("FAIL addr2 got=%h exp=02", bus.imem_addr); end
  endtask

  task automatic test_reset_in_wait;
    tick();
    checks++; if (bus.pc !== 8'h02 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL pre_rst pc=%h v=%b exp 02/0", bus.pc, bus.instr_valid); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.pc !== 8'h00 || bus.opcode !== 4'h0 || bus.operand !== 8'h00) begin errors++; $display("FAIL async_rst pc=%h op=%h opd=%h exp 00/0/00", bus.pc, bus.opcode, bus.operand); end
    checks++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.halted !== 1'b0) begin errors++; $display("FAIL async_rst_ctl req=%b v=%b h=%b exp 0/0/0", bus.imem_req, bus.instr_valid, bus.halted); end
    repeat (2) tick();
    bus.imem_rdata = 12'hFFF; bus.imem_rvalid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin errors++; $display("FAIL restart req=%b addr=%h exp req=1 addr=00", bus.imem_req, bus.imem_addr); end
    bus.imem_rvalid = 1'b0;
    tick();
    checks++; if (bus.instr_valid !== 1'b0 || bus.opcode !== 4'h0) begin errors++; $display("FAIL stale_drop v=%b op=%h exp 0/0", bus.instr_valid, bus.opcode); end
    bus.imem_rdata = 12'h100; bus.imem_rvalid = 1'b1;
    tick();
    bus.imem_rvalid = 1'b0;
    checks++; if (bus.instr_valid !== 1'b1 || bus.opcode !== 4'h1 || bus.operand !== 8'h00) begin errors++; $display("FAIL fresh_data v=%b op=%h opd=%h exp 1/1/00", bus.instr_valid, bus.opcode, bus.operand); end
  endtask

  task automatic test_halt;
    accept(1'b1, 8'h03);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h03) begin errors++; $display("FAIL halt_addr req=%b addr=%h exp req=1 addr=03", bus.imem_req, bus.imem_addr); end
    respond(12'hF12, 1);
    checks++; if (bus.opcode !== 4'hF || bus.operand !== 8'h12) begin errors++; $display("FAIL hlt_fields got=%h/%h exp=f/12", bus.opcode, bus.operand); end
    accept(1'b0, 8'h00);
`ifdef FETCH_HALT_EN
    checks++; if (bus.halted !== 1'b1 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL halted h=%b v=%b exp 1/0", bus.halted, bus.instr_valid); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.imem_req !== 1'b0 || bus.pc !== 8'h04 || bus.halted !== 1'b1) begin errors++; $display("FAIL halt_hold[%0d] req=%b pc=%h h=%b exp 0/04/1", i, bus.imem_req, bus.pc, bus.halted); end
      tick();
    end
`else
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL nohalt got=%b exp=0", bus.halted); end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h04) begin errors++; $display("FAIL hlt_next req=%b addr=%h exp req=1 addr=04", bus.imem_req, bus.imem_addr); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_hold();
    test_jump_wrap();
    test_delay_spurious();
    test_reset_in_wait();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
